// File: rtl/rans_enc_ilv.sv
// rans_enc_ilv -- interleaved rANS encoder.
//
// Encodes a stream of symbols into LANES interleaved rANS states using a
// writable {freq, cum} table. Symbol k after reset or flush updates lane
// k mod LANES. Renormalisation words and flushed lane states leave through a
// single 2-word output register with valid/ready handshake.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   en_i, symb_i      symbol to encode (symb_i also addresses the table)
//   freq_wr_i         write freq_i/cum_freq_i into table[symb_i]
//   restart_i         flush every lane state, then reinitialise
//   out_ready_i       downstream accepts the current output beat
//   ready_o           a request is accepted this cycle
//   valid_o, enc_o    output beat: 01 low word only, 11 both words
//   flush_done_o      pulse after the final flush beat is accepted
//   err_o             sticky: a symbol with zero frequency was encoded
module rans_enc_ilv #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int LANES        = 2,
    parameter int STATE_WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [SYMBOL_WIDTH-1:0]   symb_i,
    input  logic                      freq_wr_i,
    input  logic [RESOLUTION-1:0]     freq_i,
    input  logic [RESOLUTION-1:0]     cum_freq_i,
    input  logic                      restart_i,
    input  logic                      out_ready_i,
    output logic                      ready_o,
    output logic [1:0]                valid_o,
    output logic [2*SYMBOL_WIDTH-1:0] enc_o,
    output logic                      flush_done_o,
    output logic                      err_o
);
    localparam int SW  = SYMBOL_WIDTH;
    localparam int OW  = 2 * SYMBOL_WIDTH;
    localparam int QW  = STATE_WIDTH - 1 - RESOLUTION;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BPL = STATE_WIDTH / OW;
    localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int DCW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [STATE_WIDTH-1:0] L_INIT =
        {{SW{1'b0}}, 1'b1, {(STATE_WIDTH-1-SW){1'b0}}};
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BPL - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, RENORM, DIV, FLUSH} state_t;
    state_t state, state_n;

    logic [RESOLUTION-1:0]  freq_tab [2**SW];
    logic [RESOLUTION-1:0]  cum_tab  [2**SW];
    logic [RESOLUTION-1:0]  rd_freq, rd_cum;
    logic [STATE_WIDTH-1:0] lanes [LANES];
    logic [LW-1:0]          ptr, flane;
    logic [BW-1:0]          fbeat;
    logic                   fl_wait;
    logic [DCW-1:0]         div_cnt;
    logic [STATE_WIDTH-1:0] x_work;
    logic [RESOLUTION:0]    rem;
    logic [QW-1:0]          quo;
    logic [1:0]             valid_r;
    logic [OW-1:0]          enc_r;
    logic                   flush_done_r, err_r;

    // strobes from the FSM
    logic acc_en, acc_wr, acc_rst, rn_err, rn_go, rn_load, div_last, fl_load, fl_done;

    logic                   out_free;
    logic [STATE_WIDTH-1:0] t_thr, x_a, x_rn, lane_new;
    logic                   emit1, emit2, ge;
    logic [RESOLUTION+1:0]  trial;
    logic [RESOLUTION:0]    rem_n;
    logic [QW-1:0]          quo_n;
    logic [OW-1:0]          flush_word;

    assign out_free = (valid_r == 2'b00) || out_ready_i;
    assign ready_o  = (state == IDLE) && out_free && !rst_i;

    // T = (L >> RESOLUTION) * 2^SYMBOL_WIDTH * freq reduces to freq * 2^QW
    assign t_thr = {1'b0, rd_freq, {QW{1'b0}}};
    assign emit1 = (x_work >= t_thr);
    assign x_a   = x_work >> SW;
    assign emit2 = emit1 && (x_a >= t_thr);
    assign x_rn  = emit2 ? (x_a >> SW) : (emit1 ? x_a : x_work);

    // Restoring division step. The renormalised x is below freq * 2^QW, so its
    // top bits already form a partial remainder smaller than freq and only QW
    // quotient bits remain to be produced.
    assign trial    = {rem, quo[QW-1]};
    assign ge       = (trial >= {2'b00, rd_freq});
    assign rem_n    = ge ? (RESOLUTION+1)'(trial - {2'b00, rd_freq}) : trial[RESOLUTION:0];
    assign quo_n    = {quo[QW-2:0], ge};
    assign lane_new = {1'b0, quo_n, {RESOLUTION{1'b0}}}
                    + STATE_WIDTH'(rem_n) + STATE_WIDTH'(rd_cum);

    assign flush_word = OW'(lanes[flane] >> (fbeat * OW));

    assign valid_o      = valid_r;
    assign enc_o        = enc_r;
    assign flush_done_o = flush_done_r;
    assign err_o        = err_r;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        acc_en   = 1'b0;
        acc_wr   = 1'b0;
        acc_rst  = 1'b0;
        rn_err   = 1'b0;
        rn_go    = 1'b0;
        rn_load  = 1'b0;
        div_last = 1'b0;
        fl_load  = 1'b0;
        fl_done  = 1'b0;
        case (state)
            IDLE: begin
                if (ready_o) begin
                    if (restart_i) begin
                        acc_rst = 1'b1;
                        state_n = FLUSH;
                    end else if (freq_wr_i) begin
                        acc_wr = 1'b1;
                    end else if (en_i) begin
                        acc_en  = 1'b1;
                        state_n = LOOKUP;
                    end
                end
            end
            LOOKUP: state_n = RENORM;
            RENORM: begin
                if (rd_freq == '0) begin
                    rn_err  = 1'b1;
                    state_n = IDLE;
                end else if (!emit1 || out_free) begin
                    rn_go   = 1'b1;
                    rn_load = emit1;
                    state_n = DIV;
                end
            end
            DIV: begin
                if (div_cnt == '0) begin
                    div_last = 1'b1;
                    state_n  = IDLE;
                end
            end
            FLUSH: begin
                if (!fl_wait) begin
                    fl_load = out_free;
                end else if (valid_r != 2'b00 && out_ready_i) begin
                    fl_done = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) lanes[i] <= L_INIT;
            ptr          <= '0;
            flane        <= '0;
            fbeat        <= '0;
            fl_wait      <= 1'b0;
            div_cnt      <= '0;
            valid_r      <= 2'b00;
            enc_r        <= '0;
            flush_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            flush_done_r <= fl_done;
            if (valid_r != 2'b00 && out_ready_i) valid_r <= 2'b00;
            if (rn_err) err_r <= 1'b1;
            if (rn_load) begin
                valid_r <= emit2 ? 2'b11 : 2'b01;
                enc_r   <= {(emit2 ? x_a[SW-1:0] : {SW{1'b0}}), x_work[SW-1:0]};
            end
            if (rn_go)              div_cnt <= DCW'(QW - 1);
            else if (state == DIV)  div_cnt <= div_cnt - 1'b1;
            if (div_last) begin
                lanes[ptr] <= lane_new;
                ptr        <= (ptr == LAST_LANE) ? '0 : ptr + 1'b1;
            end
            if (acc_rst) begin
                flane   <= LAST_LANE;
                fbeat   <= '0;
                fl_wait <= 1'b0;
            end
            if (fl_load) begin
                valid_r <= 2'b11;
                enc_r   <= flush_word;
                if (fbeat == LAST_BEAT) begin
                    fbeat <= '0;
                    if (flane == '0) fl_wait <= 1'b1;
                    else             flane   <= flane - 1'b1;
                end else begin
                    fbeat <= fbeat + 1'b1;
                end
            end
            if (fl_done) begin
                for (int i = 0; i < LANES; i++) lanes[i] <= L_INIT;
                ptr <= '0;
            end
        end
    end

    // Table and arithmetic working registers carry no reset.
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            freq_tab[symb_i] <= freq_i;
            cum_tab[symb_i]  <= cum_freq_i;
        end
        if (acc_en) begin
            rd_freq <= freq_tab[symb_i];
            rd_cum  <= cum_tab[symb_i];
        end
        if (state == LOOKUP) x_work <= lanes[ptr];
        if (rn_go) begin
            rem <= x_rn[STATE_WIDTH-1:QW];
            quo <= x_rn[QW-1:0];
        end else if (state == DIV) begin
            rem <= rem_n;
            quo <= quo_n;
        end
    end
endmodule

// File: tb/tb_rans_enc_ilv.sv
// Testbench for rans_enc_ilv with default parameters.
module tb_rans_enc_ilv;
    localparam int RES   = 10;
    localparam int LANES = 2;
    localparam int QW    = 32 - 1 - RES;
    localparam logic [31:0] L = 32'h0080_0000;

    logic        clk = 1'b0;
    logic        rst, en, freq_wr, restart, out_ready;
    logic [7:0]  symb;
    logic [9:0]  freq, cum;
    logic        ready, flush_done, err;
    logic [1:0]  valid;
    logic [15:0] enc;

    always #5 clk = ~clk;

    rans_enc_ilv dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .symb_i(symb), .freq_wr_i(freq_wr),
        .freq_i(freq), .cum_freq_i(cum), .restart_i(restart), .out_ready_i(out_ready),
        .ready_o(ready), .valid_o(valid), .enc_o(enc), .flush_done_o(flush_done),
        .err_o(err)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [15:0] e;
        logic [15:0] m;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_b;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic [31:0] m_lane [LANES];
    int          m_ptr;
    logic [9:0]  m_freq [256];
    logic [9:0]  m_cum  [256];
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int k = 0;
        while (ready !== 1'b1 && k < 300) begin
            tick;
            k++;
        end
        chk("ready_wait", ready, 1);
    endtask

    // Beat completion: valid and out_ready both high across the next posedge.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid !== 2'b00 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {14'b0, valid, enc}, 32'h0);
            end else begin
                mon_b = sb.pop_front();
                chk("beat_valid", valid, mon_b.v);
                chk("beat_word", enc & mon_b.m, mon_b.e);
            end
        end
        if (rst === 1'b0 && flush_done === 1'b1) n_done++;
    end

    task automatic wr_tab(input logic [7:0] s, input logic [9:0] f, input logic [9:0] c);
        wait_ready;
        symb = s; freq = f; cum = c; freq_wr = 1'b1;
        tick;
        freq_wr = 1'b0;
        m_freq[s] = f;
        m_cum[s]  = c;
    endtask

    // hold > 0: keep out_ready low from the accept onward to stall the output.
    task automatic encode(input logic [7:0] s, input int hold);
        logic [63:0] x, thr;
        logic [7:0]  w [3];
        logic [9:0]  f, c;
        int          nb, cnt;
        wait_ready;
        f = m_freq[s];
        c = m_cum[s];
        nb = 0;
        if (f == 0) begin
            m_err = 1'b1;
        end else begin
            x   = 64'(m_lane[m_ptr]);
            thr = (64'(L) >> RES) * 256 * 64'(f);
            while (x >= thr && nb < 3) begin
                w[nb] = x[7:0];
                x = x >> 8;
                nb++;
            end
            if (nb == 1)      sb.push_back('{2'b01, {8'h00, w[0]}, 16'h00FF});
            else if (nb >= 2) sb.push_back('{2'b11, {w[1], w[0]}, 16'hFFFF});
            x = (x / 64'(f)) * 1024 + (x % 64'(f)) + 64'(c);
            m_lane[m_ptr] = x[31:0];
            m_ptr = (m_ptr + 1) % LANES;
        end
        symb = s;
        en = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        tick;
        en = 1'b0;
        if (hold > 0) begin
            repeat (hold) tick;
            chk("stall_ready", ready, (nb > 0) ? 0 : 1);
            if (nb > 0) chk("stall_valid", valid, (nb == 1) ? 2'b01 : 2'b11);
            out_ready = 1'b1;
            wait_ready;
        end else begin
            cnt = 1;
            while (ready !== 1'b1 && cnt < 300) begin
                tick;
                cnt++;
            end
            chk("ready_latency", cnt, (f == 0) ? 3 : QW + 3);
        end
        chk("err_flag", err, m_err);
    endtask

    task automatic flush(input int hold);
        int k;
        int done0;
        wait_ready;
        for (int l = LANES - 1; l >= 0; l--)
            for (int b = 0; b < 2; b++)
                sb.push_back('{2'b11, m_lane[l][16*b +: 16], 16'hFFFF});
        for (int l = 0; l < LANES; l++) m_lane[l] = L;
        m_ptr = 0;
        done0 = n_done;
        restart = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        tick;
        restart = 1'b0;
        if (hold > 0) begin
            tick;
            for (int i = 0; i < hold; i++) begin
                chk("hold_valid", valid, 2'b11);
                chk("hold_word", enc, sb[0].e);
                tick;
            end
            out_ready = 1'b1;
        end
        k = 0;
        while (flush_done !== 1'b1 && k < 300) begin
            tick;
            k++;
        end
        chk("flush_done_seen", flush_done, 1);
        tick;
        chk("flush_done_width", flush_done, 0);
        chk("flush_done_count", n_done - done0, 1);
        chk("flush_beats_left", sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; freq_wr = 1'b0; restart = 1'b0; out_ready = 1'b1;
        symb = 8'h00; freq = '0; cum = '0;
        for (int l = 0; l < LANES; l++) m_lane[l] = L;
        m_ptr = 0;
        m_err = 1'b0;
        repeat (3) tick;
        chk("rst_ready", ready, 0);
        chk("rst_valid", valid, 0);
        chk("rst_enc", enc, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick;
        chk("ready_after_rst", ready, 1);

        wr_tab(8'h41, 10'd512, 10'd0);
        encode(8'h41, 0);
        flush(10);
        flush(0);

        wr_tab(8'h00, 10'd1, 10'd0);
        encode(8'h00, 0);

        // freq_wr outranks en: the write happens, the symbol is dropped
        wait_ready;
        symb = 8'h05; freq = 10'd0; cum = 10'd0; freq_wr = 1'b1; en = 1'b1;
        tick;
        freq_wr = 1'b0; en = 1'b0;
        m_freq[8'h05] = 10'd0;
        m_cum[8'h05]  = 10'd0;
        chk("wr_drops_en", ready, 1);
        flush(0);

        encode(8'h05, 0);
        encode(8'h41, 0);
        flush(0);
        chk("err_sticky", err, 1);

        // mixed symbols across both lanes, including two-word renormalisation
        wr_tab(8'h7F, 10'd3, 10'd1021);
        for (int i = 0; i < 10; i++) encode((i % 3 == 2) ? 8'h7F : 8'h00, 0);
        flush(0);
        encode(8'h00, QW + 6);
        flush(0);

        // reset during DIV
        wait_ready;
        symb = 8'h41; en = 1'b1;
        tick;
        en = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        #1;
        chk("middiv_ready", ready, 0);
        chk("middiv_valid", valid, 0);
        chk("middiv_enc", enc, 0);
        chk("middiv_flush_done", flush_done, 0);
        chk("middiv_err", err, 0);
        for (int l = 0; l < LANES; l++) m_lane[l] = L;
        m_ptr = 0;
        m_err = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk("ready_after_middiv", ready, 1);
        flush(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rans_enc_ilv.md
RANS_ENC_ILV -- requirements
Module: rans_enc_ilv

Interface
REQ-001 SHALL have parameter RESOLUTION, default 10: probability resolution in bits; frequencies sum to 2^RESOLUTION.
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8: symbol width and output word width.
REQ-003 SHALL have parameter LANES, default 2: number of interleaved rANS states, range 1..8.
REQ-004 SHALL have parameter STATE_WIDTH, default 32: state width, a multiple of 2*SYMBOL_WIDTH; RESOLUTION <= 2*SYMBOL_WIDTH.
REQ-005 SHALL have the following ports; derived constants L = 2^(STATE_WIDTH-1-SYMBOL_WIDTH) and QW = STATE_WIDTH-1-RESOLUTION.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  symbol valid.
- symb_i  in  SYMBOL_WIDTH  symbol, or table address on freq_wr_i.
- freq_wr_i  in  1  write freq_i/cum_freq_i to table[symb_i].
- freq_i  in  RESOLUTION  symbol frequency.
- cum_freq_i  in  RESOLUTION  cumulative frequency.
- restart_i  in  1  flush all lane states, then reinitialise.
- out_ready_i  in  1  downstream accepts output beat.
- ready_o  out  1  block accepts en_i/freq_wr_i/restart_i this cycle.
- valid_o  out  2  00 none, 01 low word valid, 11 both words valid.
- enc_o  out  2*SYMBOL_WIDTH  output beat; first-emitted word in [SYMBOL_WIDTH-1:0].
- flush_done_o  out  1  one-cycle pulse after the last flush beat is accepted.
- err_o  out  1  sticky: encode attempted with zero frequency.

Function
REQ-006 SHALL hold a 2^SYMBOL_WIDTH-entry table of {freq, cum}, read one cycle after address presentation, not cleared by reset.
REQ-007 SHALL hold LANES state registers; symbol k after reset/flush updates lane k mod LANES.
REQ-008 SHALL implement FSM states IDLE, LOOKUP, RENORM, DIV, FLUSH.
REQ-009 SHALL assert ready_o only in IDLE with no output beat pending (valid_o=00 or out_ready_i=1).
REQ-010 SHALL apply IDLE request priority restart_i > freq_wr_i > en_i; the lower requests in a cycle are dropped, not queued.
REQ-011 SHALL complete freq_wr_i in one cycle and remain in IDLE.
REQ-012 SHALL, on en_i accept, latch symb_i and enter LOOKUP; the next cycle enters RENORM.
REQ-013 SHALL, in RENORM with freq=0, set err_o, leave the lane state and lane pointer unchanged, and return to IDLE.
REQ-014 SHALL, in RENORM, with threshold T = (L >> RESOLUTION) * 2^SYMBOL_WIDTH * freq, and while x >= T, shift x right by SYMBOL_WIDTH and emit the low word (0, 1 or 2 words).
REQ-015 SHALL, when RENORM emits one or more words, load the output register and stall in RENORM until the output register is free.
REQ-016 SHALL compute q = x/freq and r = x mod freq in DIV by restoring division, one quotient bit per cycle, QW cycles.
REQ-017 SHALL, on the last DIV cycle, write lane state = q*2^RESOLUTION + r + cum, advance the lane pointer modulo LANES, and enter IDLE.
REQ-018 SHALL, with no backpressure, raise ready_o again QW+3 cycles after the accept cycle.
REQ-019 SHALL hold enc_o/valid_o stable while valid_o!=00 and out_ready_i=0; a beat completes on valid_o!=00 and out_ready_i=1.
REQ-020 SHALL, in FLUSH, emit lanes in order LANES-1 down to 0, each as STATE_WIDTH/(2*SYMBOL_WIDTH) beats of valid_o=11, least-significant word first.
REQ-021 SHALL, after the last flush beat completes, pulse flush_done_o, set all lanes to L, set the lane pointer to 0, and enter IDLE.
REQ-022 SHALL keep every lane state in [L, 2^(STATE_WIDTH-1)) at all times.

Reset
REQ-023 SHALL, while rst_i is asserted at any time (including mid-DIV or mid-FLUSH), force FSM to IDLE, all lanes to L, lane pointer to 0, valid_o=00, enc_o=0, flush_done_o=0, err_o=0 and ready_o=0.
REQ-024 SHALL assert ready_o in the first clock edge after rst_i deasserts.

Verification
REQ-025 Write table[0x41]={512,0}; encode 0x41 -> no output beat; lane0 = 0x01000000; ready_o returns 24 cycles after accept.
REQ-026 Then assert restart_i -> beats 0x0000, 0x0080 (lane1 = 0x00800000), then 0x0000, 0x0100 (lane0); flush_done_o pulses once; lanes = 0x00800000.
REQ-027 Write table[0x00]={1,0}; encode 0x00 -> one beat valid_o=01 with enc_o[7:0]=0x00; lane0 = 0x02000000.
REQ-028 Encode a symbol with freq=0 -> err_o=1 and stays 1; no beat; the next valid symbol still goes to lane 0.
REQ-029 Hold out_ready_i=0 during the REQ-026 flush for 10 cycles -> enc_o/valid_o stable; the beat sequence is unchanged after release.
REQ-030 Assert rst_i during DIV -> all outputs reach reset values; a following flush emits L for every lane.
